// File: rtl/bc_guess_scorer.sv
// Bulls-and-cows game core: loads a secret, then scores each guess over four cycles
// and tracks attempts until the game is won or lost.
module bc_guess_scorer #(
  parameter int unsigned DIGIT_W   = 3,
  parameter int unsigned MAX_TRIES = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] inp_a,
  input  logic [DIGIT_W-1:0] inp_b,
  input  logic [DIGIT_W-1:0] inp_c,
  input  logic [DIGIT_W-1:0] inp_d,
  input  logic               save,
  output logic [2:0]         bulls,
  output logic [2:0]         cows,
  output logic [3:0]         attempts,
  output logic               result_valid,
  output logic               secret_loaded,
  output logic               busy,
  output logic               dup_err,
  output logic               win,
  output logic               lose
);

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned ATT_W      = 4;
  localparam int unsigned IDX_W      = 2;

  typedef enum logic [2:0] {
    S_WAIT_SECRET,
    S_READY,
    S_SCORE,
    S_REPORT,
    S_WIN,
    S_LOSE
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [DIGIT_W-1:0] r_secret [NUM_DIGITS];
  logic [DIGIT_W-1:0] r_guess  [NUM_DIGITS];
  logic [DIGIT_W-1:0] w_digits [NUM_DIGITS];
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_bull_acc;
  logic [CNT_W-1:0]   r_cow_acc;
  logic [CNT_W-1:0]   r_bulls;
  logic [CNT_W-1:0]   r_cows;
  logic [ATT_W-1:0]   r_attempts;
  logic               r_result_valid;
  logic               r_secret_loaded;
  logic               r_busy;
  logic               r_dup_err;
  logic               r_win;
  logic               r_lose;

  logic               w_dup;
  logic [DIGIT_W-1:0] w_guess_digit;
  logic               w_is_bull;
  logic               w_in_secret;
  logic [ATT_W-1:0]   w_att_inc;
  logic               w_win_now;
  logic               w_lose_now;

  assign w_digits[0] = inp_a;
  assign w_digits[1] = inp_b;
  assign w_digits[2] = inp_c;
  assign w_digits[3] = inp_d;

  assign w_dup = (inp_a == inp_b) || (inp_a == inp_c) || (inp_a == inp_d) ||
                 (inp_b == inp_c) || (inp_b == inp_d) || (inp_c == inp_d);

  assign w_guess_digit = r_guess[r_idx];
  assign w_is_bull     = (w_guess_digit == r_secret[r_idx]);

  // Cow: the current guess digit appears at some other secret position
  always_comb begin
    w_in_secret = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((IDX_W'(j) != r_idx) && (r_secret[j] == w_guess_digit)) w_in_secret = 1'b1;
    end
  end

  assign w_att_inc  = (r_attempts == '1) ? r_attempts : r_attempts + ATT_W'(1);
  assign w_win_now  = (r_bull_acc == CNT_W'(NUM_DIGITS));
  assign w_lose_now = (w_att_inc == ATT_W'(MAX_TRIES));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_WAIT_SECRET;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT_SECRET: if (save && !w_dup) w_next = S_READY;
      S_READY:       if (save && !w_dup) w_next = S_SCORE;
      S_SCORE:       if (r_idx == IDX_W'(NUM_DIGITS - 1)) w_next = S_REPORT;
      S_REPORT: begin
        if (w_win_now)       w_next = S_WIN;
        else if (w_lose_now) w_next = S_LOSE;
        else                 w_next = S_READY;
      end
      S_WIN, S_LOSE: if (save) w_next = S_WAIT_SECRET;
      default:       w_next = S_WAIT_SECRET;
    endcase
  end

  // Datapath and registered outputs, keyed on the current state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_secret[i] <= '0;
        r_guess[i]  <= '0;
      end
      r_idx           <= '0;
      r_bull_acc      <= '0;
      r_cow_acc       <= '0;
      r_bulls         <= '0;
      r_cows          <= '0;
      r_attempts      <= '0;
      r_result_valid  <= 1'b0;
      r_secret_loaded <= 1'b0;
      r_busy          <= 1'b0;
      r_dup_err       <= 1'b0;
      r_win           <= 1'b0;
      r_lose          <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      r_dup_err      <= 1'b0;
      case (r_state)
        S_WAIT_SECRET: begin
          if (save) begin
            if (w_dup) begin
              r_dup_err <= 1'b1;
            end else begin
              for (int i = 0; i < NUM_DIGITS; i++) r_secret[i] <= w_digits[i];
              r_secret_loaded <= 1'b1;
              r_attempts      <= '0;
            end
          end
        end
        S_READY: begin
          if (save) begin
            if (w_dup) begin
              r_dup_err <= 1'b1;
            end else begin
              for (int i = 0; i < NUM_DIGITS; i++) r_guess[i] <= w_digits[i];
              r_bull_acc <= '0;
              r_cow_acc  <= '0;
              r_idx      <= '0;
              r_busy     <= 1'b1;
            end
          end
        end
        S_SCORE: begin
          if (w_is_bull)        r_bull_acc <= r_bull_acc + CNT_W'(1);
          else if (w_in_secret) r_cow_acc  <= r_cow_acc + CNT_W'(1);
          r_idx <= r_idx + IDX_W'(1);
        end
        S_REPORT: begin
          r_bulls        <= r_bull_acc;
          r_cows         <= r_cow_acc;
          r_result_valid <= 1'b1;
          r_attempts     <= w_att_inc;
          r_busy         <= 1'b0;
          if (w_win_now)       r_win  <= 1'b1;
          else if (w_lose_now) r_lose <= 1'b1;
        end
        S_WIN, S_LOSE: begin
          if (save) begin
            r_win           <= 1'b0;
            r_lose          <= 1'b0;
            r_bulls         <= '0;
            r_cows          <= '0;
            r_attempts      <= '0;
            r_secret_loaded <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bulls         = r_bulls;
  assign cows          = r_cows;
  assign attempts      = r_attempts;
  assign result_valid  = r_result_valid;
  assign secret_loaded = r_secret_loaded;
  assign busy          = r_busy;
  assign dup_err       = r_dup_err;
  assign win           = r_win;
  assign lose          = r_lose;

endmodule

// File: tb/tb_bc_guess_scorer.sv
// Self-checking bench for bc_guess_scorer: directed game scenarios plus randomized
// play, compared against a transaction-level game model.
module tb_bc_guess_scorer;

  localparam int unsigned MAX_TRIES = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] inp_a, inp_b, inp_c, inp_d;
  logic       save;
  logic [2:0] bulls, cows;
  logic [3:0] attempts;
  logic       result_valid, secret_loaded, busy, dup_err, win, lose;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: phase 0 wait-secret, 1 ready, 2 won, 3 lost
  int m_phase;
  int m_sec[4];
  int m_att;
  int m_bulls;
  int m_cows;

  bc_guess_scorer #(.DIGIT_W(3), .MAX_TRIES(MAX_TRIES)) dut (
    .clk(clk), .rst(rst),
    .inp_a(inp_a), .inp_b(inp_b), .inp_c(inp_c), .inp_d(inp_d),
    .save(save),
    .bulls(bulls), .cows(cows), .attempts(attempts),
    .result_valid(result_valid), .secret_loaded(secret_loaded),
    .busy(busy), .dup_err(dup_err), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit has_dup(input int g[4]);
    int cnt[8];
    foreach (cnt[i]) cnt[i] = 0;
    foreach (g[i]) cnt[g[i]]++;
    foreach (cnt[i]) if (cnt[i] > 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_score(input int g[4], input int s[4], output int b, output int c);
    b = 0;
    c = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (g[i] == s[j]) begin
          if (i == j) b++;
          else        c++;
        end
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_bulls"}, 32'(bulls), 32'(m_bulls));
    chk({tag, "_cows"}, 32'(cows), 32'(m_cows));
    chk({tag, "_attempts"}, 32'(attempts), 32'(m_att));
    chk({tag, "_loaded"}, 32'(secret_loaded), 32'(m_phase != 0));
    chk({tag, "_win"}, 32'(win), 32'(m_phase == 2));
    chk({tag, "_lose"}, 32'(lose), 32'(m_phase == 3));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_zero"},
        32'({bulls, cows, attempts, result_valid, secret_loaded, busy, dup_err, win, lose}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    save = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_phase = 0; m_att = 0; m_bulls = 0; m_cows = 0;
    check_all_zero("reset");
  endtask

  // One save of digits g; inject>0 pulses another save that many cycles into scoring.
  task automatic do_save(input int g[4], input int inject);
    bit dup;
    dup = has_dup(g);
    @(negedge clk);
    inp_a = 3'(g[0]); inp_b = 3'(g[1]); inp_c = 3'(g[2]); inp_d = 3'(g[3]);
    save = 1'b1;
    @(negedge clk);
    save = 1'b0;
    case (m_phase)
      0: begin
        if (!dup) begin
          m_sec = g;
          m_phase = 1;
          m_att = 0;
        end
        chk("secret_dup_err", 32'(dup_err), 32'(dup));
        chk("secret_rv", 32'(result_valid), 32'd0);
        check_idle_outputs("secret");
      end
      1: begin
        if (dup) begin
          chk("guess_dup_err", 32'(dup_err), 32'd1);
          chk("guess_dup_busy", 32'(busy), 32'd0);
          chk("guess_dup_rv", 32'(result_valid), 32'd0);
          check_idle_outputs("guess_dup");
        end else begin
          chk("guess_busy", 32'(busy), 32'd1);
          chk("guess_dup_err0", 32'(dup_err), 32'd0);
          for (int i = 1; i <= 5; i++) begin
            if (i == inject) begin
              inp_a = 3'($urandom_range(7)); inp_b = 3'($urandom_range(7));
              inp_c = 3'($urandom_range(7)); inp_d = 3'($urandom_range(7));
              save = 1'b1;
            end
            @(negedge clk);
            save = 1'b0;
            chk("score_rv", 32'(result_valid), 32'(i == 5));
            chk("score_dup_err", 32'(dup_err), 32'd0);
            if (i < 5) chk("score_busy", 32'(busy), 32'd1);
          end
          model_score(g, m_sec, m_bulls, m_cows);
          if (m_att < 15) m_att++;
          if (m_bulls == 4) m_phase = 2;
          else if (m_att == int'(MAX_TRIES)) m_phase = 3;
          check_idle_outputs("result");
          if (m_phase == 1) chk("result_busy", 32'(busy), 32'd0);
          @(negedge clk);
          chk("result_rv_pulse", 32'(result_valid), 32'd0);
        end
      end
      default: begin
        m_phase = 0; m_att = 0; m_bulls = 0; m_cows = 0;
        chk("clear_dup_err", 32'(dup_err), 32'd0);
        chk("clear_rv", 32'(result_valid), 32'd0);
        check_idle_outputs("clear");
      end
    endcase
  endtask

  task automatic rand_distinct(output int g[4]);
    int p[8];
    int k, t;
    foreach (p[i]) p[i] = i;
    for (int i = 7; i > 0; i--) begin
      k = int'($urandom_range(i));
      t = p[i]; p[i] = p[k]; p[k] = t;
    end
    for (int i = 0; i < 4; i++) g[i] = p[i];
  endtask

  initial begin
    int g[4];
    rst = 1'b1; save = 1'b0;
    inp_a = '0; inp_b = '0; inp_c = '0; inp_d = '0;
    m_phase = 0; m_att = 0; m_bulls = 0; m_cows = 0;
    repeat (2) @(negedge clk);
    do_reset();

    // Basic scoring, then full-reverse guess, then win and clear
    g = '{1, 2, 3, 4}; do_save(g, 0);
    g = '{1, 3, 2, 7}; do_save(g, 0);
    chk("tp1_bulls", 32'(bulls), 32'd1);
    chk("tp1_cows", 32'(cows), 32'd2);
    g = '{4, 3, 2, 1}; do_save(g, 2);
    chk("tp2_cows", 32'(cows), 32'd4);
    g = '{1, 2, 3, 4}; do_save(g, 0);
    chk("tp2_win", 32'(win), 32'd1);
    chk("tp2_attempts", 32'(attempts), 32'd3);
    g = '{0, 5, 6, 7}; do_save(g, 0);

    // Duplicate handling in both waiting states
    g = '{5, 5, 1, 2}; do_save(g, 0);
    g = '{0, 1, 2, 3}; do_save(g, 0);
    g = '{0, 6, 6, 7}; do_save(g, 0);

    // Exhaust the tries with zero-score guesses; the last try must lose
    for (int n = 0; n < int'(MAX_TRIES); n++) begin
      g = '{4, 5, 6, 7}; do_save(g, (n % 3 == 0) ? 5 : 0);
    end
    chk("tp4_lose", 32'(lose), 32'd1);
    chk("tp4_attempts", 32'(attempts), 32'(MAX_TRIES));
    g = '{4, 5, 6, 7}; do_save(g, 0);

    // Reset in the middle of scoring
    g = '{3, 1, 0, 6}; do_save(g, 0);
    @(negedge clk);
    inp_a = 3'd3; inp_b = 3'd1; inp_c = 3'd6; inp_d = 3'd0; save = 1'b1;
    @(negedge clk);
    save = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_phase = 0; m_att = 0; m_bulls = 0; m_cows = 0;
    check_all_zero("midreset");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midreset_rv", 32'(result_valid), 32'd0);
    end

    // Randomized play
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(9) < 2) begin
        for (int i = 0; i < 4; i++) g[i] = int'($urandom_range(7));
      end else if (m_phase == 1 && $urandom_range(9) == 0) begin
        g = m_sec;
      end else begin
        rand_distinct(g);
      end
      do_save(g, ($urandom_range(4) == 0) ? int'($urandom_range(1, 5)) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
